// File: rtl/pwm_seq_pkg.sv
// rtl/pwm_seq_pkg.sv - shared offsets, CTRL bit indices and sequencer state type
package pwm_seq_pkg;

  localparam logic [3:0] REG_CTRL       = 4'h0;
  localparam logic [3:0] REG_START_DUTY = 4'h4;
  localparam logic [3:0] REG_END_DUTY   = 4'h8;
  localparam logic [3:0] REG_CFG        = 4'hC;

  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_LOOP     = 2;
  localparam int CTRL_DONE_CLR = 3;
  localparam int CTRL_IRQ_EN   = 4;

  // Register offsets of the PWM block on the master port
  localparam logic [3:0] PWM_REG_CTRL   = 4'h0;
  localparam logic [3:0] PWM_REG_PERIOD = 4'h4;
  localparam logic [3:0] PWM_REG_DUTY   = 4'h8;
  localparam logic [3:0] PWM_REG_STATUS = 4'hC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

  function automatic logic [15:0] min_one16(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/pwm_seq_bus_mux.sv
// rtl/pwm_seq_bus_mux.sv - CPU/sequencer master arbitration and read-data mux
module pwm_seq_bus_mux (
  input  logic        cpu_sel,
  input  logic        cpu_pwm_sel,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] reg_rdata,
  input  logic [31:0] pwm_rdata,
  input  logic        seq_req,
  input  logic [3:0]  seq_addr,
  input  logic [31:0] seq_wdata,
  output logic [31:0] rdata,
  output logic        pwm_sel,
  output logic        pwm_we,
  output logic [3:0]  pwm_addr,
  output logic [31:0] pwm_wdata
);

  // The CPU always owns the master port when it addresses the PWM window
  always_comb begin
    pwm_sel   = 1'b0;
    pwm_we    = 1'b0;
    pwm_addr  = 4'h0;
    pwm_wdata = 32'h0;
    if (cpu_pwm_sel) begin
      pwm_sel   = 1'b1;
      pwm_we    = cpu_we;
      pwm_addr  = cpu_addr;
      pwm_wdata = cpu_wdata;
    end else if (seq_req) begin
      pwm_sel   = 1'b1;
      pwm_we    = 1'b1;
      pwm_addr  = seq_addr;
      pwm_wdata = seq_wdata;
    end
  end

  // Own window wins the read path on an illegal double select
  always_comb begin
    rdata = 32'h0;
    if (cpu_sel) begin
      rdata = reg_rdata;
    end else if (cpu_pwm_sel) begin
      rdata = pwm_rdata;
    end
  end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// rtl/pwm_seq_ctrl.sv - PWM duty ramp sequencer with CPU pass-through arbitration
module pwm_seq_ctrl
  import pwm_seq_pkg::*;
#(
  parameter logic [3:0] PWM_DUTY_ADDR = PWM_REG_DUTY,
  parameter int         IVL_W         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_sel,
  input  logic        i_pwm_sel,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_pwm_sel,
  output logic        o_pwm_we,
  output logic [3:0]  o_pwm_addr,
  output logic [31:0] o_pwm_wdata,
  input  logic [31:0] i_pwm_rdata,
  output logic        o_busy,
  output logic        o_irq
);

  seq_state_t        state, state_nxt;
  logic [31:0]       start_duty, end_duty, cfg;
  logic              loop_en, irq_en;
  logic [31:0]       cur, lo, hi;
  logic              dir, done;
  logic [IVL_W-1:0]  cnt;
  logic              busy_q, irq_q;

  logic              wr_en, ctrl_wr, start_p, stop_p, clr_p;
  logic              fire, done_set, load_wait, do_step, do_swap;
  logic              done_nxt, irq_en_nxt;
  logic [31:0]       step_eff, diff, step_val;
  logic [IVL_W-1:0]  ivl_field, ivl_eff;
  logic [31:0]       status, reg_rdata;

  assign wr_en   = i_sel && i_we;
  assign ctrl_wr = wr_en && (i_addr == REG_CTRL);
  assign stop_p  = ctrl_wr && i_wdata[CTRL_STOP];
  assign start_p = ctrl_wr && i_wdata[CTRL_START] && !i_wdata[CTRL_STOP];
  assign clr_p   = ctrl_wr && i_wdata[CTRL_DONE_CLR];

  assign step_eff  = {16'h0, min_one16(cfg[15:0])};
  assign ivl_field = cfg[16 +: IVL_W];
  assign ivl_eff   = (ivl_field == '0) ? IVL_W'(1) : ivl_field;

  // Clamp to the target so the last step never overshoots or wraps
  assign diff     = dir ? (hi - cur) : (cur - hi);
  assign step_val = (diff <= step_eff) ? hi : (dir ? (cur + step_eff) : (cur - step_eff));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    done_set  = 1'b0;
    load_wait = 1'b0;
    do_step   = 1'b0;
    do_swap   = 1'b0;
    if (stop_p) begin
      state_nxt = IDLE;
    end else if (start_p) begin
      state_nxt = WRITE;
    end else begin
      case (state)
        WRITE: begin
          if (!i_pwm_sel) begin
            fire = 1'b1;
            if (cur == hi && !loop_en) begin
              done_set  = 1'b1;
              state_nxt = IDLE;
            end else begin
              do_swap   = (cur == hi);
              load_wait = 1'b1;
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == IVL_W'(1)) begin
            do_step   = 1'b1;
            state_nxt = WRITE;
          end
        end
        IDLE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A completing write beats a simultaneous DONE_CLR
  assign done_nxt   = start_p ? 1'b0 : (done_set ? 1'b1 : (clr_p ? 1'b0 : done));
  assign irq_en_nxt = ctrl_wr ? i_wdata[CTRL_IRQ_EN] : irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_duty <= 32'h0;
      end_duty   <= 32'h0;
      cfg        <= 32'h0;
      loop_en    <= 1'b0;
      irq_en     <= 1'b0;
      cur        <= 32'h0;
      lo         <= 32'h0;
      hi         <= 32'h0;
      dir        <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (i_addr)
          REG_CTRL:       loop_en    <= i_wdata[CTRL_LOOP];
          REG_START_DUTY: start_duty <= i_wdata;
          REG_END_DUTY:   end_duty   <= i_wdata;
          REG_CFG:        cfg        <= i_wdata;
          default:        ;
        endcase
      end
      irq_en <= irq_en_nxt;
      if (start_p) begin
        cur <= start_duty;
        lo  <= start_duty;
        hi  <= end_duty;
        dir <= (end_duty >= start_duty);
      end else begin
        if (do_swap) begin
          lo  <= hi;
          hi  <= lo;
          dir <= !dir;
        end
        if (load_wait) begin
          cnt <= ivl_eff;
        end else if (state == WAIT) begin
          cnt <= cnt - IVL_W'(1);
        end
        if (do_step) begin
          cur <= step_val;
        end
      end
      done   <= done_nxt;
      busy_q <= (state_nxt != IDLE);
      irq_q  <= done_nxt && irq_en_nxt;
    end
  end

  always_comb begin
    status            = 32'h0;
    status[0]         = busy_q;
    status[1]         = done;
    status[2]         = loop_en;
    status[3]         = dir;
    status[4]         = irq_en;
    status[31:16]     = cur[15:0];
  end

  always_comb begin
    reg_rdata = 32'h0;
    case (i_addr)
      REG_CTRL:       reg_rdata = status;
      REG_START_DUTY: reg_rdata = start_duty;
      REG_END_DUTY:   reg_rdata = end_duty;
      REG_CFG:        reg_rdata = cfg;
      default:        reg_rdata = 32'h0;
    endcase
  end

  pwm_seq_bus_mux u_bus_mux (
    .cpu_sel     (i_sel),
    .cpu_pwm_sel (i_pwm_sel),
    .cpu_we      (i_we),
    .cpu_addr    (i_addr),
    .cpu_wdata   (i_wdata),
    .reg_rdata   (reg_rdata),
    .pwm_rdata   (i_pwm_rdata),
    .seq_req     (fire),
    .seq_addr    (PWM_DUTY_ADDR),
    .seq_wdata   (cur),
    .rdata       (o_rdata),
    .pwm_sel     (o_pwm_sel),
    .pwm_we      (o_pwm_we),
    .pwm_addr    (o_pwm_addr),
    .pwm_wdata   (o_pwm_wdata)
  );

  assign o_busy = busy_q;
  assign o_irq  = irq_q;

endmodule
